// File: rtl/vector_sweep_pkg.sv
// vector_sweep_pkg: sweep FSM states and sizing helpers shared by
// the truth-table sweep sequencer and its settle timer.
package vector_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } sweep_state_t;

  localparam int N_IN_DEF = 3;

  function automatic int vec_count(input int n);
    return 1 << n;
  endfunction

  function automatic int err_width(input int n);
    return n + 1;
  endfunction

  function automatic int timer_width(input int settle);
    int w;
    w = $clog2(settle + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/vector_sweep_ctrl_settle_timer.sv
// settle_timer: loadable down-counter that stops at zero and
// flags when the settle interval has elapsed.
module settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/vector_sweep_ctrl.sv
// vector_sweep_ctrl: sweeps all input vectors of a small DUT and counts
// mismatches against a latched truth table. Option: VECTOR_SWEEP_ERRLOG_EN.
module vector_sweep_ctrl
  import vector_sweep_pkg::*;
#(
  parameter int N_IN       = N_IN_DEF,
  parameter int SETTLE_CYC = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [vec_count(N_IN)-1:0]     truth_tbl,
  output logic [N_IN-1:0]                dut_in,
  input  logic                           dut_y,
  output logic                           busy,
  output logic                           done,
  output logic [err_width(N_IN)-1:0]     err_cnt,
  output logic                           pass
`ifdef VECTOR_SWEEP_ERRLOG_EN
  ,
  output logic                           first_err_vld,
  output logic [N_IN-1:0]                first_err_vec
`endif
);

  localparam int NV = vec_count(N_IN);
  localparam int EW = err_width(N_IN);
  localparam int TW = timer_width(SETTLE_CYC);
  localparam logic [N_IN-1:0] LAST = '1;

  sweep_state_t    state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [NV-1:0]   tbl_q, tbl_d;
  logic [EW-1:0]   err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tmr_ld, tmr_dec, tmr_zero;
  logic            mismatch;

`ifdef VECTOR_SWEEP_ERRLOG_EN
  logic            fe_vld_q, fe_vld_d;
  logic [N_IN-1:0] fe_vec_q, fe_vec_d;
`endif

  settle_timer #(
    .W(TW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_ld),
    .load_val_i (TW'(SETTLE_CYC)),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // Case inequality so an X/Z response is scored as a mismatch
  assign mismatch = (dut_y !== tbl_q[vec_q]);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    tbl_d   = tbl_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
    tmr_ld  = 1'b0;
    tmr_dec = 1'b0;
`ifdef VECTOR_SWEEP_ERRLOG_EN
    fe_vld_d = fe_vld_q;
    fe_vec_d = fe_vec_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          tbl_d   = truth_tbl;
          vec_d   = '0;
          tmr_ld  = 1'b1;
          err_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = SETTLE;
`ifdef VECTOR_SWEEP_ERRLOG_EN
          fe_vld_d = 1'b0;
          fe_vec_d = '0;
`endif
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          state_d = SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + EW'(1);
`ifdef VECTOR_SWEEP_ERRLOG_EN
          if (!fe_vld_q) begin
            fe_vld_d = 1'b1;
            fe_vec_d = vec_q;
          end
`endif
        end
        if (vec_q == LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          vec_d   = vec_q + N_IN'(1);
          tmr_ld  = 1'b1;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      tbl_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      tbl_q   <= tbl_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef VECTOR_SWEEP_ERRLOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fe_vld_q <= 1'b0;
      fe_vec_q <= '0;
    end else begin
      fe_vld_q <= fe_vld_d;
      fe_vec_q <= fe_vec_d;
    end
  end

  assign first_err_vld = fe_vld_q;
  assign first_err_vec = fe_vec_q;
`endif

  // The driven vector is the sweep register itself
  assign dut_in  = vec_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err_cnt = err_q;
  assign pass    = done_q && (err_q == '0);

endmodule

// File: tb/tb_vector_sweep_ctrl.sv
// tb_vector_sweep_ctrl: two sequencers (SETTLE_CYC=1 and 0) checked each
// cycle against a slot-arithmetic model, plus directed literal checks.
module tb_vector_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_s [2];
  logic [7:0] tbl_s   [2];
  logic [7:0] g_tbl   [2];
  logic [2:0] din     [2];
  logic       y_s     [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  logic [3:0] err_o   [2];
  logic       pass_o  [2];
`ifdef VECTOR_SWEEP_ERRLOG_EN
  logic       fev_o   [2];
  logic [2:0] fevec_o [2];
`endif

  int nvec = 0;
  int nfail = 0;

  int       mc    [2] = '{0, 0};
  bit       mbusy [2] = '{0, 0};
  bit       mdone [2] = '{0, 0};
  int       merr  [2] = '{0, 0};
  int       mfe   [2] = '{-1, -1};
  bit [7:0] mtbl  [2] = '{0, 0};

  always #5 clk = ~clk;

  assign y_s[0] = g_tbl[0][din[0]];
  assign y_s[1] = g_tbl[1][din[1]];

  vector_sweep_ctrl #(.N_IN(3), .SETTLE_CYC(1)) dut0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .truth_tbl(tbl_s[0]),
    .dut_in(din[0]), .dut_y(y_s[0]), .busy(busy_o[0]), .done(done_o[0]),
    .err_cnt(err_o[0]), .pass(pass_o[0])
`ifdef VECTOR_SWEEP_ERRLOG_EN
    , .first_err_vld(fev_o[0]), .first_err_vec(fevec_o[0])
`endif
  );

  vector_sweep_ctrl #(.N_IN(3), .SETTLE_CYC(0)) dut1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .truth_tbl(tbl_s[1]),
    .dut_in(din[1]), .dut_y(y_s[1]), .busy(busy_o[1]), .done(done_o[1]),
    .err_cnt(err_o[1]), .pass(pass_o[1])
`ifdef VECTOR_SWEEP_ERRLOG_EN
    , .first_err_vld(fev_o[1]), .first_err_vec(fevec_o[1])
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Sweep model: cycle c after the accepting edge shows vector c/per;
  // the last cycle of each slot is the one whose response is scored.
  task automatic model_edge(input int i, input int s);
    int per;
    int v;
    per = s + 2;
    if (!mbusy[i]) begin
      if (start_s[i]) begin
        mbusy[i] = 1;
        mdone[i] = 0;
        mc[i]    = 0;
        merr[i]  = 0;
        mfe[i]   = -1;
        mtbl[i]  = tbl_s[i];
      end
    end else begin
      if (mc[i] % per == per - 1) begin
        v = mc[i] / per;
        if (g_tbl[i][v] != mtbl[i][v]) begin
          merr[i]++;
          if (mfe[i] < 0) mfe[i] = v;
        end
      end
      mc[i]++;
      if (mc[i] == 8 * per) begin
        mbusy[i] = 0;
        mdone[i] = 1;
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        mbusy[i] = 0; mdone[i] = 0; mc[i] = 0;
        merr[i] = 0; mfe[i] = -1; mtbl[i] = 0;
      end
    end else begin
      model_edge(0, 1);
      model_edge(1, 0);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int per;
      int ev;
      per = (i == 0) ? 3 : 2;
      ev = mbusy[i] ? mc[i] / per : (mdone[i] ? 7 : 0);
      chk($sformatf("dut_in[%0d]", i), int'(din[i]), ev);
      chk($sformatf("busy[%0d]", i), int'(busy_o[i]), int'(mbusy[i]));
      chk($sformatf("done[%0d]", i), int'(done_o[i]), int'(mdone[i]));
      chk($sformatf("err_cnt[%0d]", i), int'(err_o[i]), merr[i]);
      chk($sformatf("pass[%0d]", i), int'(pass_o[i]),
          int'(mdone[i] && merr[i] == 0));
`ifdef VECTOR_SWEEP_ERRLOG_EN
      chk($sformatf("fe_vld[%0d]", i), int'(fev_o[i]), int'(mfe[i] >= 0));
      chk($sformatf("fe_vec[%0d]", i), int'(fevec_o[i]),
          (mfe[i] >= 0) ? mfe[i] : 0);
`endif
    end
  end

  task automatic wait_vec(input int i, input int v);
    int n;
    n = 0;
    while (int'(din[i]) != v && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk($sformatf("timeout_vec[%0d]", i), 0, 1);
  endtask

  task automatic wait_done(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_o[i] && n < 100);
    if (n >= 100) chk($sformatf("timeout_done[%0d]", i), 0, 1);
  endtask

  task automatic pulse(input int i);
    start_s[i] = 1'b1;
    @(negedge clk);
    start_s[i] = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start_s[0] = 0; start_s[1] = 0;
    tbl_s[0] = 0; tbl_s[1] = 0;
    g_tbl[0] = 0; g_tbl[1] = 0;
    repeat (2) @(negedge clk);
    chk("rst_dut_in", int'(din[0]), 0);
    chk("rst_busy", int'(busy_o[0]), 0);
    chk("rst_pass", int'(pass_o[0]), 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: matching DUT on dut0; 3: y=~a against 3C on dut1
    tbl_s[0] = 8'hA5; g_tbl[0] = 8'hA5;
    tbl_s[1] = 8'h3C; g_tbl[1] = 8'h0F;
    start_s[0] = 1; start_s[1] = 1;
    @(negedge clk);
    start_s[0] = 0; start_s[1] = 0;
    chk("s1_busy_edge0", int'(busy_o[0]), 1);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 4) chk("s1_vec1_at_edge4", int'(din[0]), 1);
      if (k == 15) chk("s3_done_edge15", int'(done_o[1]), 0);
      if (k == 16) chk("s3_done_edge16", int'(done_o[1]), 1);
      if (k == 16) chk("s3_err", int'(err_o[1]), 4);
      if (k == 23) chk("s1_done_edge23", int'(done_o[0]), 0);
    end
    chk("s1_done_edge24", int'(done_o[0]), 1);
    chk("s1_err", int'(err_o[0]), 0);
    chk("s1_pass", int'(pass_o[0]), 1);
`ifdef VECTOR_SWEEP_ERRLOG_EN
    chk("s3_fe_vec", int'(fevec_o[1]), 0);
`endif

    // 2: stuck-at-0 DUT
    g_tbl[0] = 8'h00;
    pulse(0);
    wait_done(0);
    chk("s2_err", int'(err_o[0]), 4);
    chk("s2_pass", int'(pass_o[0]), 0);
`ifdef VECTOR_SWEEP_ERRLOG_EN
    chk("s2_fe_vld", int'(fev_o[0]), 1);
    chk("s2_fe_vec", int'(fevec_o[0]), 0);
`endif

    // 4: start and table change mid-sweep are ignored
    g_tbl[0] = 8'hA5;
    pulse(0);
    wait_vec(0, 3);
    start_s[0] = 1; tbl_s[0] = 8'h00;
    @(negedge clk);
    start_s[0] = 0;
    chk("s4_no_restart", int'(din[0]), 3);
    wait_done(0);
    chk("s4_err", int'(err_o[0]), 0);
    chk("s4_pass", int'(pass_o[0]), 1);

    // 5: asynchronous reset mid-sweep
    tbl_s[0] = 8'hA5;
    pulse(0);
    wait_vec(0, 5);
    #2 reset = 1'b1;
    #1;
    chk("s5_dut_in", int'(din[0]), 0);
    chk("s5_busy", int'(busy_o[0]), 0);
    chk("s5_err", int'(err_o[0]), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pulse(0);
    wait_done(0);
    chk("s5_pass", int'(pass_o[0]), 1);

    // 6: start held through DONE restarts at once
    g_tbl[0] = 8'h00;
    start_s[0] = 1;
    wait_done(0);
    chk("s6_err_first", int'(err_o[0]), 4);
    @(negedge clk);
    chk("s6_done_one_cycle", int'(done_o[0]), 0);
    chk("s6_busy", int'(busy_o[0]), 1);
    chk("s6_err_clr", int'(err_o[0]), 0);
    chk("s6_dut_in", int'(din[0]), 0);
    start_s[0] = 0;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!mbusy[i] && $urandom_range(3) == 0) g_tbl[i] = 8'($urandom);
        if ($urandom_range(1) == 0) tbl_s[i] = 8'($urandom);
        start_s[i] = ($urandom_range(7) == 0);
      end
      if (c % 700 == 350) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    start_s[0] = 0; start_s[1] = 0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
